// File: rtl/axi_pkg.sv
// Shared AXI constants, the write-buffer entry record and the issue FSM
// state encoding used by the axi_wr_queue slice.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_4B     = 3'b010;

   // Entries carry the widest supported line; narrower lines leave the top bits zero
   localparam int MAX_LINE_WIDTH = 512;

   typedef struct packed {
      logic [31:0]               addr;
      logic [MAX_LINE_WIDTH-1:0] data;
      logic                      burst;
      logic [1:0]                size;
      logic [3:0]                strb;
   } wr_entry_t;

   typedef enum logic [1:0] {
      ISS_PEND    = 2'b00,
      ISS_AW_DONE = 2'b01,
      ISS_W_DONE  = 2'b10,
      ISS_DONE    = 2'b11
   } iss_state_t;

endpackage

// File: rtl/axi_wr_issue.sv
// Drives the AXI3 AW and W channels for one presented buffer entry, tracking
// AW and W completion independently, and pulses o_issue_done once both finish.
module axi_wr_issue
   import axi_pkg::*;
#(
   parameter int WORDS_PER_LINE = 4,
   parameter int LINE_WIDTH     = WORDS_PER_LINE * 32,
   parameter int AXI_ID         = 1
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_valid,
   input  wr_entry_t   i_entry,
   output logic [3:0]  o_awid,
   output logic [31:0] o_awaddr,
   output logic [7:0]  o_awlen,
   output logic [2:0]  o_awsize,
   output logic [1:0]  o_awburst,
   output logic        o_awvalid,
   input  logic        i_awready,
   output logic [3:0]  o_wid,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_wlast,
   output logic        o_wvalid,
   input  logic        i_wready,
   output logic        o_issue_done
);

   localparam int              BEAT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
   localparam logic [7:0]      BURST_LEN = 8'(WORDS_PER_LINE - 1);

   iss_state_t            r_state;
   iss_state_t            w_state_nxt;
   logic [BEAT_W-1:0]     r_beat;
   logic [LINE_WIDTH-1:0] w_line;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_wlast_hs;
   logic                  w_unused;

   assign w_line   = i_entry.data[LINE_WIDTH-1:0];
   assign w_unused = ^i_entry.data;

   generate
      if (WORDS_PER_LINE > 1) begin : g_multi
         assign o_wdata = w_line[{r_beat, 5'b00000} +: 32];
      end else begin : g_single
         assign o_wdata = w_line[31:0];
      end
   endgenerate

   assign o_awid    = 4'(AXI_ID);
   assign o_wid     = 4'(AXI_ID);
   assign o_awaddr  = i_entry.addr;
   assign o_awlen   = i_entry.burst ? BURST_LEN : 8'd0;
   assign o_awsize  = i_entry.burst ? SIZE_4B : {1'b0, i_entry.size};
   assign o_awburst = i_entry.burst ? BURST_INCR : BURST_FIXED;
   assign o_wstrb   = i_entry.burst ? 4'b1111 : i_entry.strb;
   assign o_wlast   = i_entry.burst ? (r_beat == LAST_BEAT) : 1'b1;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= ISS_PEND;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The DONE state is a one-cycle bubble in which the top advances to the next entry
   always_comb begin
      w_state_nxt  = r_state;
      o_issue_done = 1'b0;
      o_awvalid    = i_valid & ((r_state == ISS_PEND) | (r_state == ISS_W_DONE));
      o_wvalid     = i_valid & ((r_state == ISS_PEND) | (r_state == ISS_AW_DONE));
      w_aw_hs      = o_awvalid & i_awready;
      w_w_hs       = o_wvalid & i_wready;
      w_wlast_hs   = w_w_hs & o_wlast;
      case (r_state)
         ISS_PEND: begin
            if (w_aw_hs && w_wlast_hs) w_state_nxt = ISS_DONE;
            else if (w_aw_hs)          w_state_nxt = ISS_AW_DONE;
            else if (w_wlast_hs)       w_state_nxt = ISS_W_DONE;
         end
         ISS_AW_DONE: if (w_wlast_hs) w_state_nxt = ISS_DONE;
         ISS_W_DONE:  if (w_aw_hs)    w_state_nxt = ISS_DONE;
         ISS_DONE: begin
            o_issue_done = 1'b1;
            w_state_nxt  = ISS_PEND;
         end
         default: w_state_nxt = ISS_PEND;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_beat <= '0;
      end else if (w_w_hs) begin
         r_beat <= o_wlast ? '0 : r_beat + 1'b1;
      end
   end

endmodule

// File: rtl/axi_wr_queue.sv
// In-order AXI3 write queue between D-cache and crossbar with B-side retire and
// line hazard check. Define AXI_WR_QUEUE_BRESP_ERR_EN to record bus errors.
module axi_wr_queue
   import axi_pkg::*;
#(
   parameter int BYTES_PER_LINE = 16,
   parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
   parameter int LINE_WIDTH     = WORDS_PER_LINE * 32,
   parameter int DEPTH          = 4,
   parameter int AXI_ID         = 1
) (
   input  logic                  i_clk,
   input  logic                  i_resetn,
   input  logic                  i_wr_req,
   output logic                  o_wr_rdy,
   input  logic                  i_burst,
   input  logic [LINE_WIDTH-1:0] i_data,
   input  logic [31:0]           i_addr,
   input  logic [1:0]            i_size,
   input  logic [3:0]            i_strb,
   input  logic [31:0]           i_chk_addr,
   output logic                  o_chk_hit,
   output logic                  o_wr_idle,
   output logic [3:0]            o_awid,
   output logic [31:0]           o_awaddr,
   output logic [7:0]            o_awlen,
   output logic [2:0]            o_awsize,
   output logic [1:0]            o_awburst,
   output logic [1:0]            o_awlock,
   output logic [3:0]            o_awcache,
   output logic [2:0]            o_awprot,
   output logic                  o_awvalid,
   input  logic                  i_awready,
   output logic [3:0]            o_wid,
   output logic [31:0]           o_wdata,
   output logic [3:0]            o_wstrb,
   output logic                  o_wlast,
   output logic                  o_wvalid,
   input  logic                  i_wready,
   input  logic [3:0]            i_bid,
   input  logic [1:0]            i_bresp,
   input  logic                  i_bvalid,
   output logic                  o_bready,
   output logic                  o_wr_err,
   output logic [31:0]           o_wr_err_addr
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam int             OFF_W    = $clog2(BYTES_PER_LINE);
   localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

   // Pointers carry one wrap bit so full and empty are distinguishable
   logic [PTR_W:0]   r_enq;
   logic [PTR_W:0]   r_iss;
   logic [PTR_W:0]   r_ret;
   logic [DEPTH-1:0] r_valid;
   wr_entry_t        r_mem [DEPTH];
   wr_entry_t        w_new_entry;
   logic [PTR_W:0]   w_occ;
   logic             w_enq;
   logic             w_pending;
   logic             w_issue_done;
   logic             w_retire;
   logic             w_unused;

   assign w_occ     = r_enq - r_ret;
   assign o_wr_rdy  = (w_occ != FULL_OCC);
   assign o_wr_idle = (w_occ == '0);
   assign w_enq     = i_wr_req & o_wr_rdy;
   assign w_pending = (r_iss != r_enq);
   assign o_bready  = 1'b1;
   assign o_awlock  = 2'b00;
   assign o_awcache = 4'b0000;
   assign o_awprot  = 3'b000;

   // The head entry counts as outstanding during its DONE bubble, so an early B still retires it
   assign w_retire  = i_bvalid & ((r_ret != r_iss) | w_issue_done);

   always_comb begin
      w_new_entry                       = '0;
      w_new_entry.addr                  = i_addr;
      w_new_entry.data[LINE_WIDTH-1:0]  = i_data;
      w_new_entry.burst                 = i_burst;
      w_new_entry.size                  = i_size;
      w_new_entry.strb                  = i_strb;
   end

   always_ff @(posedge i_clk) begin
      if (w_enq) r_mem[r_enq[PTR_W-1:0]] <= w_new_entry;
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_enq   <= '0;
         r_iss   <= '0;
         r_ret   <= '0;
         r_valid <= '0;
      end else begin
         if (w_enq) begin
            r_enq                   <= r_enq + 1'b1;
            r_valid[r_enq[PTR_W-1:0]] <= 1'b1;
         end
         if (w_issue_done) r_iss <= r_iss + 1'b1;
         if (w_retire) begin
            r_ret                   <= r_ret + 1'b1;
            r_valid[r_ret[PTR_W-1:0]] <= 1'b0;
         end
      end
   end

   always_comb begin
      o_chk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_mem[i].addr[31:OFF_W] == i_chk_addr[31:OFF_W])) o_chk_hit = 1'b1;
      end
   end

   axi_wr_issue #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .LINE_WIDTH     (LINE_WIDTH),
      .AXI_ID         (AXI_ID)
   ) u_issue (
      .i_clk        (i_clk),
      .i_resetn     (i_resetn),
      .i_valid      (w_pending),
      .i_entry      (r_mem[r_iss[PTR_W-1:0]]),
      .o_awid       (o_awid),
      .o_awaddr     (o_awaddr),
      .o_awlen      (o_awlen),
      .o_awsize     (o_awsize),
      .o_awburst    (o_awburst),
      .o_awvalid    (o_awvalid),
      .i_awready    (i_awready),
      .o_wid        (o_wid),
      .o_wdata      (o_wdata),
      .o_wstrb      (o_wstrb),
      .o_wlast      (o_wlast),
      .o_wvalid     (o_wvalid),
      .i_wready     (i_wready),
      .o_issue_done (w_issue_done)
   );

`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
   logic        r_err;
   logic [31:0] r_err_addr;

   // Only the first failing write's address is kept; the flag stays set until reset
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else if (w_retire && i_bresp[1]) begin
         r_err <= 1'b1;
         if (!r_err) r_err_addr <= r_mem[r_ret[PTR_W-1:0]].addr;
      end
   end

   assign o_wr_err      = r_err;
   assign o_wr_err_addr = r_err_addr;
   assign w_unused      = ^{i_bid, i_bresp[0], i_chk_addr[OFF_W-1:0]};
`else
   assign o_wr_err      = 1'b0;
   assign o_wr_err_addr = '0;
   assign w_unused      = ^{i_bid, i_bresp, i_chk_addr[OFF_W-1:0]};
`endif

endmodule

// File: tb/tb_axi_wr_queue.sv
// Directed self-checking bench for axi_wr_queue with the default 16-byte line
// and 4-entry buffer; error checks adapt to AXI_WR_QUEUE_BRESP_ERR_EN.
module tb_axi_wr_queue;

   localparam int LW = 128;

`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          resetn;
   logic          wr_req;
   logic          wr_rdy;
   logic          burst;
   logic [LW-1:0] data;
   logic [31:0]   addr;
   logic [1:0]    size;
   logic [3:0]    strb;
   logic [31:0]   chk_addr;
   logic          chk_hit;
   logic          wr_idle;
   logic [3:0]    awid;
   logic [31:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic [1:0]    awlock;
   logic [3:0]    awcache;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;
   logic [3:0]    wid;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wlast;
   logic          wvalid;
   logic          wready;
   logic [3:0]    bid;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic          wr_err;
   logic [31:0]   wr_err_addr;

   int checks = 0;
   int errors = 0;

   axi_wr_queue dut (
      .i_clk(clk), .i_resetn(resetn), .i_wr_req(wr_req), .o_wr_rdy(wr_rdy),
      .i_burst(burst), .i_data(data), .i_addr(addr), .i_size(size), .i_strb(strb),
      .i_chk_addr(chk_addr), .o_chk_hit(chk_hit), .o_wr_idle(wr_idle),
      .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
      .o_awburst(awburst), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
      .o_awvalid(awvalid), .i_awready(awready),
      .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
      .o_wvalid(wvalid), .i_wready(wready),
      .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
      .o_wr_err(wr_err), .o_wr_err_addr(wr_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic b, input logic [31:0] a, input logic [LW-1:0] d,
                          input logic [1:0] sz, input logic [3:0] st);
      wr_req = 1'b1;
      burst  = b;
      addr   = a;
      data   = d;
      size   = sz;
      strb   = st;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (awvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_awvalid got %0b want 0", awvalid); end
      checks++; if (wvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wvalid got %0b want 0", wvalid); end
      checks++; if (wr_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_rdy got %0b want 1", wr_rdy); end
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_idle got %0b want 1", wr_idle); end
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_chk_hit got %0b want 0", chk_hit); end
      checks++; if (bready !== 1'b1) begin errors++; $display("[TB] FAIL reset_bready got %0b want 1", bready); end
      checks++; if (wr_err !== 1'b0 || wr_err_addr !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_err got %0b/%h want 0/00000000", wr_err, wr_err_addr); end
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single_store();
      awready = 1'b0;
      wready  = 1'b0;
      set_req(1'b0, 32'h1000_0004, {96'h0, 32'hCAFE_F00D}, 2'd2, 4'b1100);
      tick();
      wr_req = 1'b0;
      checks++; if (awvalid !== 1'b1 || awaddr !== 32'h1000_0004) begin
         errors++; $display("[TB] FAIL single_aw got v=%0b a=%h want v=1 a=10000004", awvalid, awaddr); end
      checks++; if (awlen !== 8'd0 || awburst !== 2'b00 || awsize !== 3'b010) begin
         errors++; $display("[TB] FAIL single_awattr got len=%0d burst=%b size=%b want 0/00/010", awlen, awburst, awsize); end
      checks++; if (awid !== 4'd1 || wid !== 4'd1 || awlock !== 2'b0 || awcache !== 4'b0 || awprot !== 3'b0) begin
         errors++; $display("[TB] FAIL single_ids got awid=%0d wid=%0d lock=%b cache=%b prot=%b want 1/1/0/0/0", awid, wid, awlock, awcache, awprot); end
      checks++; if (wvalid !== 1'b1 || wdata !== 32'hCAFE_F00D || wstrb !== 4'b1100 || wlast !== 1'b1) begin
         errors++; $display("[TB] FAIL single_w got v=%0b d=%h s=%b l=%0b want 1/cafef00d/1100/1", wvalid, wdata, wstrb, wlast); end
      awready = 1'b1;
      wready  = 1'b1;
      tick();
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
         errors++; $display("[TB] FAIL single_after_hs got aw=%0b w=%0b want 0/0", awvalid, wvalid); end
      tick();
      bvalid = 1'b1;
      bresp  = 2'b00;
      checks++; if (wr_idle !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %0b want 0", wr_idle); end
      tick();
      bvalid = 1'b0;
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle got %0b want 1", wr_idle); end
   endtask

   task automatic test_line_write();
      logic [31:0] words [4];
      logic        exp_last;
      words[0] = 32'h1111_1111;
      words[1] = 32'h2222_2222;
      words[2] = 32'h3333_3333;
      words[3] = 32'h4444_4444;
      awready = 1'b0;
      wready  = 1'b1;
      set_req(1'b1, 32'h2000_0040, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 2'd0, 4'b0000);
      tick();
      wr_req = 1'b0;
      for (int b = 0; b < 4; b++) begin
         exp_last = (b == 3);
         checks++; if (wvalid !== 1'b1 || wdata !== words[b] || wlast !== exp_last || wstrb !== 4'b1111) begin
            errors++; $display("[TB] FAIL line_beat%0d got v=%0b d=%h l=%0b s=%b want 1/%h/%0b/1111", b, wvalid, wdata, wlast, wstrb, words[b], exp_last); end
         tick();
      end
      checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
         errors++; $display("[TB] FAIL line_w_done got w=%0b aw=%0b want 0/1", wvalid, awvalid); end
      checks++; if (awaddr !== 32'h2000_0040 || awlen !== 8'd3 || awburst !== 2'b01 || awsize !== 3'b010) begin
         errors++; $display("[TB] FAIL line_aw got a=%h len=%0d burst=%b size=%b want 20000040/3/01/010", awaddr, awlen, awburst, awsize); end
      tick();
      checks++; if (awvalid !== 1'b1) begin errors++; $display("[TB] FAIL line_aw_held got %0b want 1", awvalid); end
      awready = 1'b1;
      tick();
      checks++; if (awvalid !== 1'b0) begin errors++; $display("[TB] FAIL line_aw_taken got %0b want 0", awvalid); end
      tick();
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL line_idle got %0b want 1", wr_idle); end
   endtask

   task automatic test_fill();
      logic exp_rdy;
      awready = 1'b1;
      wready  = 1'b1;
      bvalid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b0, 32'h6000_0000 + 32'(i * 4), {96'h0, 32'(i + 32'hA0)}, 2'd2, 4'b1111);
         tick();
         exp_rdy = (i < 3);
         checks++; if (wr_rdy !== exp_rdy) begin
            errors++; $display("[TB] FAIL fill_rdy%0d got %0b want %0b", i, wr_rdy, exp_rdy); end
      end
      set_req(1'b0, 32'h6000_0100, {96'h0, 32'h0000_00FF}, 2'd2, 4'b1111);
      tick();
      tick();
      checks++; if (wr_rdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_held got %0b want 0", wr_rdy); end
      wr_req = 1'b0;
      repeat (8) tick();
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || wr_idle !== 1'b0) begin
         errors++; $display("[TB] FAIL fill_issued got aw=%0b w=%0b idle=%0b want 0/0/0", awvalid, wvalid, wr_idle); end
      bvalid = 1'b1;
      tick();
      checks++; if (wr_rdy !== 1'b1) begin errors++; $display("[TB] FAIL fill_rdy_after_b got %0b want 1", wr_rdy); end
      repeat (3) tick();
      bvalid = 1'b0;
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL fill_drained got %0b want 1", wr_idle); end
   endtask

   task automatic test_hazard();
      awready  = 1'b0;
      wready   = 1'b0;
      set_req(1'b1, 32'h3000_0080, 128'hDDDD_0003_DDDD_0002_DDDD_0001_DDDD_0000, 2'd0, 4'b0000);
      chk_addr = 32'h3000_008C;
      #1;
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL hazard_same_cycle got %0b want 0", chk_hit); end
      tick();
      wr_req = 1'b0;
      checks++; if (chk_hit !== 1'b1) begin errors++; $display("[TB] FAIL hazard_buffered got %0b want 1", chk_hit); end
      chk_addr = 32'h3000_0090;
      #1;
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL hazard_next_line got %0b want 0", chk_hit); end
      chk_addr = 32'h3000_008C;
      awready  = 1'b1;
      wready   = 1'b1;
      repeat (6) tick();
      checks++; if (chk_hit !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
         errors++; $display("[TB] FAIL hazard_in_flight got hit=%0b aw=%0b w=%0b want 1/0/0", chk_hit, awvalid, wvalid); end
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL hazard_retired got %0b want 0", chk_hit); end
   endtask

   task automatic test_stray_bvalid();
      awready = 1'b0;
      wready  = 1'b0;
      set_req(1'b0, 32'h7000_0000, {96'h0, 32'h1234_5678}, 2'd2, 4'b0011);
      tick();
      wr_req = 1'b0;
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      checks++; if (wr_idle !== 1'b0 || awvalid !== 1'b1) begin
         errors++; $display("[TB] FAIL stray_b_ignored got idle=%0b aw=%0b want 0/1", wr_idle, awvalid); end
      awready = 1'b1;
      wready  = 1'b1;
      tick();
      tick();
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL stray_b_drain got %0b want 1", wr_idle); end
   endtask

   task automatic test_reset_mid_burst();
      awready  = 1'b1;
      wready   = 1'b1;
      chk_addr = 32'h4000_0004;
      set_req(1'b1, 32'h4000_0000, 128'hBEEF_0003_BEEF_0002_BEEF_0001_BEEF_0000, 2'd0, 4'b0000);
      tick();
      wr_req = 1'b0;
      tick();
      tick();
      checks++; if (wvalid !== 1'b1 || wdata !== 32'hBEEF_0002 || chk_hit !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_beat2 got w=%0b d=%h hit=%0b want 1/beef0002/1", wvalid, wdata, chk_hit); end
      resetn = 1'b0;
      #1;
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || chk_hit !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_drop got aw=%0b w=%0b hit=%0b want 0/0/0", awvalid, wvalid, chk_hit); end
      checks++; if (wr_rdy !== 1'b1 || wr_idle !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_state got rdy=%0b idle=%0b want 1/1", wr_rdy, wr_idle); end
      tick();
      resetn  = 1'b1;
      awready = 1'b0;
      wready  = 1'b0;
      set_req(1'b1, 32'h4000_0100, 128'h0BAD_0003_0BAD_0002_0BAD_0001_0BAD_0000, 2'd0, 4'b0000);
      tick();
      wr_req = 1'b0;
      checks++; if (wdata !== 32'h0BAD_0000 || wlast !== 1'b0 || awvalid !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_restart got d=%h l=%0b aw=%0b want 0bad0000/0/1", wdata, wlast, awvalid); end
      awready = 1'b1;
      wready  = 1'b1;
      repeat (6) tick();
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL midrst_drain got %0b want 1", wr_idle); end
   endtask

   task automatic test_bresp_err();
      logic        exp_err;
      logic [31:0] exp_addr;
      awready = 1'b1;
      wready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b0, 32'h5000_0000 + 32'(i * 16), {96'h0, 32'(i)}, 2'd2, 4'b1111);
         tick();
      end
      wr_req = 1'b0;
      repeat (8) tick();
      bvalid = 1'b1;
      bresp  = 2'b00;
      tick();
      checks++; if (wr_err !== 1'b0) begin errors++; $display("[TB] FAIL err_okay got %0b want 0", wr_err); end
      bresp = 2'b10;
      tick();
      exp_err  = ERR_EN;
      exp_addr = ERR_EN ? 32'h5000_0010 : 32'h0;
      checks++; if (wr_err !== exp_err || wr_err_addr !== exp_addr) begin
         errors++; $display("[TB] FAIL err_slverr got %0b/%h want %0b/%h", wr_err, wr_err_addr, exp_err, exp_addr); end
      bresp = 2'b11;
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      checks++; if (wr_err !== exp_err || wr_err_addr !== exp_addr) begin
         errors++; $display("[TB] FAIL err_decerr_keep got %0b/%h want %0b/%h", wr_err, wr_err_addr, exp_err, exp_addr); end
      checks++; if (wr_idle !== 1'b1) begin errors++; $display("[TB] FAIL err_drain got %0b want 1", wr_idle); end
   endtask

   initial begin
      resetn   = 1'b1;
      wr_req   = 1'b0;
      burst    = 1'b0;
      data     = '0;
      addr     = '0;
      size     = '0;
      strb     = '0;
      chk_addr = '0;
      awready  = 1'b1;
      wready   = 1'b1;
      bid      = 4'd1;
      bresp    = 2'b00;
      bvalid   = 1'b0;
      test_reset();
      test_single_store();
      test_line_write();
      test_fill();
      test_hazard();
      test_stray_bvalid();
      test_reset_mid_burst();
      test_bresp_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_wr_queue.md
Name: axi_wr_queue

Overview:
- Parametrised successor to the single-entry AXI3 write master that sits between the D-cache and the AXI crossbar.
- Holds up to DEPTH pending writes: dirty-line bursts or single uncached stores.
- Issues them in order, keeps several transactions outstanding on B, and exposes a line-address hazard check so the read path can stall on pending writes.

Parameters:
- BYTES_PER_LINE, 16, cache line size in bytes; power of two, 4..64.
- WORDS_PER_LINE, BYTES_PER_LINE/4, derived; beats per burst.
- LINE_WIDTH, WORDS_PER_LINE*32, derived; data bus from cache.
- DEPTH, 4, buffer entries; power of two, 2..8.
- AXI_ID, 1, constant value driven on awid/wid.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- wr_req  in  1  enqueue request
- wr_rdy  out  1  buffer can accept; enqueue = wr_req & wr_rdy
- burst  in  1  1 = full-line INCR burst, 0 = single beat
- data  in  LINE_WIDTH  line data (single beat uses data[31:0])
- addr  in  32  byte address (line-aligned when burst=1)
- size  in  2  AXI size for single beat
- strb  in  4  byte strobes for single beat
- chk_addr  in  32  address probed by the read path
- chk_hit  out  1  a buffered or outstanding entry matches chk_addr's line
- wr_idle  out  1  buffer empty and nothing outstanding
- aw*  AXI3 AW group: awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0], awvalid out; awready in
- w*  wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid out; wready in
- b*  bid[3:0], bresp[1:0], bvalid in; bready out
- wr_err  out  1  sticky bus-error flag (feature only)
- wr_err_addr  out  32  address of first failing write (feature only)

Behaviour:
- Reset (resetn=0, async): all pointers and counts 0, every entry invalid; awvalid=wvalid=0, wr_rdy=1, wr_idle=1, chk_hit=0, bready=1, wr_err=0, wr_err_addr=0.
- Circular buffer with three pointers:
  - enq_ptr: advances on enqueue.
  - iss_ptr: advances when both AW and last W of the entry have handshaken.
  - ret_ptr: advances on a B handshake (bvalid & bready).
- occupancy = enq - ret. wr_rdy = occupancy != DEPTH (no same-cycle bypass from retire).
- Enqueue and retire in the same cycle leave occupancy unchanged.
- Issue FSM per head entry (iss_ptr != enq_ptr). Two independent done flags, aw_done and w_done:
  - awvalid = entry pending & ~aw_done.
  - wvalid = entry pending & ~w_done.
  - AW and W may complete in either order or together.
  - Next entry starts the cycle after both flags are set; flags then clear.
- Beat counter: width clog2(WORDS_PER_LINE), increments on each W handshake.
  - wdata = selected word of the entry line.
  - wlast = burst ? counter all-ones : 1.
- Burst entry: awlen=WORDS_PER_LINE-1, awsize=3'b010, awburst=INCR, wstrb=4'b1111.
- Single entry: awlen=0, awsize={1'b0,size}, awburst=FIXED, wstrb=strb.
- awlock, awcache, awprot = 0; bready held 1.
- Issue is in order; B responses return in order (single ID). A bvalid when ret_ptr == iss_ptr is a protocol error and is ignored.
- chk_hit: combinational compare of addr[31:log2(BYTES_PER_LINE)] against every entry between ret_ptr and enq_ptr, including entries in flight awaiting B. Same-cycle enqueue is not visible until the next cycle.
- wr_idle = occupancy == 0.
- AXI outputs stay stable while valid and not ready.
- Reset mid-burst clears all state immediately; the interconnect is reset by the same signal.

Optional Feature:
- Macro AXI_WR_QUEUE_BRESP_ERR_EN.
- Defined: on a B handshake with bresp[1]=1 (SLVERR/DECERR), set wr_err; it is sticky until reset. wr_err_addr captures the retiring entry's address on the first error only.
- Undefined: bresp is ignored; wr_err=0 and wr_err_addr=0 constant; the error registers are not synthesised.

Decomposition:
- Shared package axi_pkg holds:
  - BURST_FIXED=2'b00 and BURST_INCR=2'b01.
  - SIZE_4B=3'b010.
  - A typedef for the buffer entry {addr, data, burst, size, strb}.
- One sub-module, axi_wr_issue: the per-entry AW/W done-flag FSM plus beat counter. It drives the AW/W channels from a presented entry and pulses issue_done.
- The pointer, occupancy, hazard and B-retire logic stays in the top.

Test Plan:
- Single store: addr=0x1000_0004, size=2, strb=4'b1100, burst=0 → one AW (awlen=0, awburst=00, awsize=010); one W beat with wstrb=1100 and wlast=1; wr_idle returns 1 one cycle after bvalid.
- Line write, WORDS_PER_LINE=4, addr=0x2000_0040, awready delayed 5 cycles while wready=1 → 4 W beats with wlast on beat 4; AW issued afterwards; then entry retires.
- Fill DEPTH=4 with bvalid held 0 → wr_rdy=0 after the 4th enqueue; a 5th wr_req is not accepted. First bvalid → wr_rdy=1 in the next cycle.
- Hazard: enqueue line 0x3000_0080, then probe chk_addr=0x3000_008C → chk_hit=1 until its B handshake. Probe 0x3000_0090 → chk_hit=0.
- Assert resetn=0 mid-burst at beat 2 → awvalid, wvalid, chk_hit drop immediately; wr_rdy=1, wr_idle=1.
- With the macro defined: bresp=2'b10 on the 2nd of 3 writes → wr_err=1 and wr_err_addr equals the 2nd write's address. A 3rd write with bresp=2'b11 leaves wr_err_addr unchanged.
